// File: rtl/relu_stream_unit.sv
`default_nettype none
// ============================================================================
// Module   : relu_stream_unit
// Brief    : Multi-lane streaming activation unit (pass / ReLU / clipped ReLU
//            / leaky ReLU) with a 2-stage valid/ready pipeline, frame-position
//            tracking (out_last) and a saturating negative-lane statistic.
// Revision : 1.0 - initial release
// ============================================================================
module relu_stream_unit #(
    parameter int DATA_SIZE  = 8,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int FRAME_LEN  = 196,
    parameter int STAT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_mode,
    input  logic [DATA_SIZE-2:0]         cfg_clip,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*DATA_SIZE-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*DATA_SIZE-1:0]   out_data,
    output logic                         out_last,
    input  logic                         stat_clr,
    output logic [STAT_W-1:0]            neg_count
);

    // ------------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------------
    // A one-beat frame still needs a 1-bit counter so the port widths stay legal.
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    // Enough bits to hold a per-beat count of 0..LANES negative lanes.
    localparam int PC_W  = $clog2(LANES + 1);
    // Wide enough that the running sum can never wrap before saturation.
    localparam int SUM_W = STAT_W + PC_W;

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_RELU  = 2'b01;
    localparam logic [1:0] MODE_CLIP  = 2'b10;
    localparam logic [1:0] MODE_LEAKY = 2'b11;

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(FRAME_LEN - 1);
    localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};
    localparam logic [SUM_W-1:0]  SUM_MAX   = SUM_W'(STAT_MAX);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]                 mode_q;
    logic [DATA_SIZE-2:0]       clip_q;

    logic                       s1_valid;
    logic [LANES*DATA_SIZE-1:0] s1_data;
    logic [1:0]                 s1_mode;
    logic [DATA_SIZE-2:0]       s1_clip;
    logic [LANES-1:0]           s1_neg;

    logic                       s2_valid;
    logic [LANES*DATA_SIZE-1:0] s2_data;

    logic [CNT_W-1:0]           beat_cnt;
    logic [STAT_W-1:0]          neg_cnt;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic                       s2_adv;
    logic                       accept;
    logic                       xfer;

    // Stage 2 may load whenever it is empty or its beat leaves this cycle.
    assign s2_adv   = !s2_valid || out_ready;
    // The unit only stalls when both stages hold beats and downstream refuses.
    assign in_ready = !s1_valid || !s2_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = s2_valid && out_ready;

    // ------------------------------------------------------------------------
    // Per-lane sign flags and activation of the stage-1 beat
    // ------------------------------------------------------------------------
    logic [LANES-1:0]           in_neg;
    logic [LANES*DATA_SIZE-1:0] act_data;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [DATA_SIZE-1:0] x;
        logic signed [DATA_SIZE-1:0] clip_ext;
        logic signed [DATA_SIZE-1:0] y;

        assign in_neg[i] = in_data[i*DATA_SIZE + DATA_SIZE - 1];
        assign x         = s1_data[i*DATA_SIZE +: DATA_SIZE];
        // Clip ceiling is a non-negative magnitude; a leading zero keeps it so.
        assign clip_ext  = {1'b0, s1_clip};

        // Select the lane result from the mode captured with this beat.
        always_comb begin
            y = x;
            case (s1_mode)
                MODE_PASS:  y = x;
                MODE_RELU:  y = s1_neg[i] ? '0 : x;
                MODE_CLIP:  y = s1_neg[i] ? '0 : ((x > clip_ext) ? clip_ext : x);
                MODE_LEAKY: y = s1_neg[i] ? (x >>> LEAK_SHIFT) : x;
                default:    y = x;
            endcase
        end

        assign act_data[i*DATA_SIZE +: DATA_SIZE] = y;
    end

    // ------------------------------------------------------------------------
    // Negative-lane statistic
    // ------------------------------------------------------------------------
    logic [PC_W-1:0]  neg_pc;
    logic [SUM_W-1:0] neg_sum;

    // Count the sign bits of the beat presented at the input.
    always_comb begin
        neg_pc = '0;
        for (int k = 0; k < LANES; k++) begin
            neg_pc = neg_pc + PC_W'(in_neg[k]);
        end
    end

    assign neg_sum = SUM_W'(neg_cnt) + SUM_W'(neg_pc);

    // Saturating accumulate on acceptance; a clear in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_cnt <= '0;
        end else if (stat_clr) begin
            neg_cnt <= '0;
        end else if (accept) begin
            neg_cnt <= (neg_sum > SUM_MAX) ? STAT_MAX : STAT_W'(neg_sum);
        end
    end

    // ------------------------------------------------------------------------
    // Run-time configuration
    // ------------------------------------------------------------------------
    // Config registers; a beat accepted on the write edge still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_RELU;
            clip_q <= '1;
        end else if (cfg_we) begin
            mode_q <= cfg_mode;
            clip_q <= cfg_clip;
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline stages
    // ------------------------------------------------------------------------
    // Stage 1: capture raw lanes together with the config and sign flags in force.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= MODE_RELU;
            s1_clip  <= '1;
            s1_neg   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_mode <= mode_q;
                s1_clip <= clip_q;
                s1_neg  <= in_neg;
            end
        end
    end

    // Stage 2: register the activated beat; data is held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= act_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame position
    // ------------------------------------------------------------------------
    // Beat index within the frame, advanced on each output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (xfer) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_last  = s2_valid && (beat_cnt == LAST_BEAT);
    assign neg_count = neg_cnt;

endmodule
`default_nettype wire

// File: tb/tb_relu_stream_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_stream_unit
// Brief    : Self-checking bench for relu_stream_unit. Two instances share the
//            stimulus: one with 4-beat frames and a 4-bit statistic, one with
//            1-beat frames and a 16-bit statistic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relu_stream_unit;

    localparam int DW = 8;
    localparam int LN = 4;
    localparam int LS = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_mode = 2'b00;
    logic [DW-2:0] cfg_clip = '0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = '0;
    logic          out_ready = 1'b1;
    logic          stat_clr = 1'b0;

    logic          in_ready, out_valid, out_last;
    logic [31:0]   out_data;
    logic [3:0]    neg_count;
    logic          in_ready1, out_valid1, out_last1;
    logic [31:0]   out_data1;
    logic [15:0]   neg_count1;

    relu_stream_unit #(.DATA_SIZE(DW), .LANES(LN), .LEAK_SHIFT(LS),
                       .FRAME_LEN(4), .STAT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
        .cfg_clip(cfg_clip), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .stat_clr(stat_clr),
        .neg_count(neg_count));

    relu_stream_unit #(.DATA_SIZE(DW), .LANES(LN), .LEAK_SHIFT(LS),
                       .FRAME_LEN(1), .STAT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
        .cfg_clip(cfg_clip), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_last(out_last1), .stat_clr(stat_clr),
        .neg_count(neg_count1));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model state ----------------
    typedef struct { int tag; logic [31:0] data; } beat_t;
    beat_t q[$];
    bit    lastq[$];
    int    cyc = 0;
    int    beats_out = 0;
    int    accepted = 0;
    int    m_mode = 1;
    int    m_clip = 127;
    int    nc4 = 0;
    int    nc16 = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [6:0]  clip;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
        pack = {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Activation from the arithmetic rules; leaky uses floor division by 2^LS.
    function automatic logic [31:0] model_act(input logic [31:0] d, input int mode, input int clip);
        logic [31:0] r;
        int x, y;
        r = '0;
        for (int i = 0; i < LN; i++) begin
            x = int'($signed(d[i*DW +: DW]));
            case (mode)
                0:       y = x;
                1:       y = (x < 0) ? 0 : x;
                2:       y = (x < 0) ? 0 : ((x > clip) ? clip : x);
                default: y = (x < 0) ? (x - ((1 << LS) - 1)) / (1 << LS) : x;
            endcase
            r[i*DW +: DW] = 8'(y);
        end
        return r;
    endfunction

    function automatic int count_neg(input logic [31:0] d);
        int n = 0;
        for (int i = 0; i < LN; i++) if ($signed(d[i*DW +: DW]) < 0) n++;
        return n;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        q.delete();
        beats_out = 0;
        m_mode = 1;
        m_clip = 127;
        nc4 = 0;
        nc16 = 0;
    endtask

    // One clock cycle: check outputs against the model, then advance both.
    // Entered and left at posedge+1 with inputs already driven.
    task automatic step();
        bit exp_ov, exp_ir, acc, xfer;
        #1;
        exp_ir = (q.size() < 2) || out_ready;
        exp_ov = (q.size() > 0) && (cyc >= q[0].tag + 1);
        chk("in_ready", in_ready, exp_ir);
        chk("in_ready_f1", in_ready1, exp_ir);
        chk("out_valid", out_valid, exp_ov);
        chk("out_valid_f1", out_valid1, exp_ov);
        if (exp_ov) begin
            chk("out_data", out_data, q[0].data);
            chk("out_data_f1", out_data1, q[0].data);
        end
        chk("out_last", out_last, exp_ov && (beats_out % 4 == 3));
        chk("out_last_f1", out_last1, exp_ov);
        chk("neg_count", neg_count, nc4);
        chk("neg_count_w16", neg_count1, nc16);
        acc  = in_valid && exp_ir;
        xfer = exp_ov && out_ready;
        if (xfer) lastq.push_back(out_last);
        @(posedge clk);
        cyc++;
        if (xfer) begin
            void'(q.pop_front());
            beats_out++;
        end
        if (acc) begin
            q.push_back('{tag: cyc, data: model_act(in_data, m_mode, m_clip)});
            accepted++;
        end
        if (stat_clr) begin
            nc4 = 0;
            nc16 = 0;
        end else if (acc) begin
            nc4  = min_i(nc4 + count_neg(in_data), 15);
            nc16 = min_i(nc16 + count_neg(in_data), 65535);
        end
        if (cfg_we) begin
            m_mode = int'(cfg_mode);
            m_clip = int'(cfg_clip);
        end
        #1;
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        cfg_we = 1'b0;
        stat_clr = 1'b0;
        out_ready = 1'b1;
        #1;
        model_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_neg_count", neg_count, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        cfg_we = 1'b0;
        stat_clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        bit [8:0] lv9;
        bit [3:0] lv4;
        int start, bstart, guard;

        vt[0] = '{2'b01, 7'd127, pack(-128, -1, 0, 127), pack(0, 0, 0, 127)};
        vt[1] = '{2'b10, 7'd20,  pack(25, 20, -5, 7),    pack(20, 20, 0, 7)};
        vt[2] = '{2'b11, 7'd127, pack(-128, -1, -8, 9),  pack(-16, -1, -1, 9)};
        vt[3] = '{2'b00, 7'd0,   pack(-128, 5, -3, 0),   pack(-128, 5, -3, 0)};
        vt[4] = '{2'b10, 7'd127, pack(-128, 127, 126, -1), pack(0, 127, 126, 0)};
        vt[5] = '{2'b10, 7'd0,   pack(5, 0, -1, 127),    pack(0, 0, 0, 0)};
        vt[6] = '{2'b11, 7'd5,   pack(-9, -7, 127, -16), pack(-2, -1, 127, -2)};

        #2;
        do_reset();

        // ---- table-driven single beats ----
        for (int i = 0; i < 7; i++) begin
            cfg_we = 1'b1; cfg_mode = vt[i].mode; cfg_clip = vt[i].clip;
            in_valid = 1'b0;
            if (i != 0) step();              // first vector runs on reset config
            cfg_we = 1'b0;
            in_valid = 1'b1; in_data = vt[i].din;
            step();
            in_valid = 1'b0;
            step();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_data", i), out_data, vt[i].dout);
            if (i == 0) chk("vec0_negcount", neg_count1, 2);
            drain();
        end

        // ---- config change on the same edge as beat A ----
        cfg_we = 1'b1; cfg_mode = 2'b01; cfg_clip = 7'd127; step();
        cfg_mode = 2'b00;
        in_valid = 1'b1; in_data = pack(-5, 3, -1, 2);
        step();
        cfg_we = 1'b0;
        step();                               // beat B, same lanes, new mode
        chk("cfg_beatA", out_data, pack(0, 3, 0, 2));
        in_valid = 1'b0;
        step();
        chk("cfg_beatB", out_data, pack(-5, 3, -1, 2));
        drain();

        // ---- 10 beats under random backpressure ----
        start = accepted; bstart = beats_out; guard = 0;
        while (((accepted - start) < 10 || q.size() > 0) && guard < 500) begin
            in_valid  = ((accepted - start) < 10) && ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = $urandom_range(0, 1) != 0;
            step();
            guard++;
        end
        chk("stream10_timeout", q.size(), 0);
        chk("stream10_count", beats_out - bstart, 10);

        // ---- long random run with config and clear activity ----
        for (int i = 0; i < 400; i++) begin
            in_valid  = $urandom_range(0, 1) != 0;
            in_data   = $urandom;
            out_ready = $urandom_range(0, 1) != 0;
            cfg_we    = $urandom_range(0, 9) == 0;
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_clip  = 7'($urandom_range(0, 127));
            stat_clr  = $urandom_range(0, 19) == 0;
            step();
        end
        drain();

        // ---- frame boundaries: 9 beats, last on beats 4 and 8 ----
        do_reset();
        cfg_we = 1'b1; cfg_mode = 2'b00; step(); cfg_we = 1'b0;
        lastq.delete();
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = $urandom;
            step();
        end
        drain();
        lv9 = '0;
        for (int i = 0; i < lastq.size() && i < 9; i++) lv9[i] = lastq[i];
        chk("frame_count", lastq.size(), 9);
        chk("frame_last", lv9, 9'b010001000);

        // ---- reset mid-stream, then counter restarts ----
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = $urandom;
            step();
        end
        do_reset();
        lastq.delete();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = $urandom;
            step();
        end
        drain();
        lv4 = '0;
        for (int i = 0; i < lastq.size() && i < 4; i++) lv4[i] = lastq[i];
        chk("post_rst_count", lastq.size(), 4);
        chk("post_rst_last", lv4, 4'b1000);

        // ---- statistic saturation and clear-wins ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = pack(-1, -2, -3, -128);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("sat_neg4", neg_count, 15);
        chk("sat_neg16", neg_count1, 20);
        stat_clr = 1'b1; in_valid = 1'b1; in_data = pack(-1, -1, -1, -1);
        step();
        stat_clr = 1'b0; in_valid = 1'b0;
        step();
        chk("clr_neg4", neg_count, 0);
        chk("clr_neg16", neg_count1, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
